// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and sizing for the ALU op sequencer.
package alu_seq_pkg;
    localparam int DATA_W   = 8;
    localparam int CNT_W    = 3;
    localparam int MUL_ITER = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/alu_seq_datapath.sv
// Operand/working registers plus shared adder and manipulator, stepped by FSM strobes.
// Result registers update on the finish strobe and hold until the next one.
module alu_seq_datapath
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              finish,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              last,
    output logic [15:0]       result,
    output logic              cout,
    output logic              zero
);
    logic [2:0]        op;
    logic [DATA_W-1:0] opa, opb, work, acc;
    logic [CNT_W-1:0]  cnt;

    logic              is_mul, is_sub, is_shift, do_step;
    logic [DATA_W-1:0] add_a, add_b, b_inv, add_sum, man_out, shift_nxt;
    logic              add_cout, man_bit;
    logic [DATA_W:0]   prod;
    logic [DATA_W-1:0] acc_nxt, q_nxt;
    logic [15:0]       res_nxt;
    logic              cout_nxt;

    assign is_mul   = (op == OP_MUL);
    assign is_sub   = (op == OP_SUB);
    assign is_shift = (op >= OP_SHL) && (op <= OP_ROR);
    assign do_step  = (cnt != '0);

    // Adder serves ADD/SUB as A +/- B and MUL as P_hi + A.
    mux2to1 #(.W(DATA_W)) u_mux_a    (.d0(opa),   .d1(acc),  .sel(is_mul), .y(add_a));
    mux2to1 #(.W(DATA_W)) u_mux_binv (.d0(opb),   .d1(~opb), .sel(is_sub), .y(b_inv));
    mux2to1 #(.W(DATA_W)) u_mux_b    (.d0(b_inv), .d1(opa),  .sel(is_mul), .y(add_b));

    bit8_full_adder u_add (
        .a(add_a), .b(add_b), .cin(is_sub), .sum(add_sum), .cout(add_cout)
    );

    // Opcodes 010..101 map to dir_right = op[0], rotate = op[2].
    bit8_manipulator u_man (
        .din(work), .dir_right(op[0]), .rotate(op[2]), .dout(man_out), .bit_out(man_bit)
    );

    mux2to1 #(.W(DATA_W)) u_mux_w (.d0(work), .d1(man_out), .sel(do_step), .y(shift_nxt));

    assign prod    = work[0] ? {add_cout, add_sum} : {1'b0, acc};
    assign acc_nxt = prod[DATA_W:1];
    assign q_nxt   = {prod[0], work[DATA_W-1:1]};

    assign last = is_mul ? (cnt == '0) : (is_shift ? (cnt <= CNT_W'(1)) : 1'b1);

    always_comb begin
        res_nxt  = 16'h0000;
        cout_nxt = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res_nxt  = {8'h00, add_sum};
                cout_nxt = add_cout;
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                res_nxt  = {8'h00, shift_nxt};
                cout_nxt = do_step & man_bit;
            end
            OP_MUL:  res_nxt = {acc_nxt, q_nxt};
            default: res_nxt = {8'h00, opa};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op     <= OP_ADD;
            opa    <= '0;
            opb    <= '0;
            work   <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            if (load) begin
                op   <= in_op;
                opa  <= in_a;
                opb  <= in_b;
                work <= (in_op == OP_MUL) ? in_b : in_a;
                acc  <= '0;
                cnt  <= (in_op == OP_MUL) ? CNT_W'(MUL_ITER - 1) : in_b[CNT_W-1:0];
            end else if (step) begin
                if (is_mul) begin
                    acc  <= acc_nxt;
                    work <= q_nxt;
                end else if (is_shift) begin
                    work <= shift_nxt;
                end
                if (do_step) cnt <= cnt - 1'b1;
            end
            if (finish) begin
                result <= res_nxt;
                cout   <= cout_nxt;
                zero   <= (res_nxt == 16'h0000);
            end
        end
    end
endmodule

// File: rtl/bit8_full_adder.sv
// 8-bit ripple-carry adder; combinational, no handshake.
module bit8_full_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[8];
endmodule

// File: rtl/bit8_manipulator.sv
// One-step shift/rotate of an 8-bit word; combinational, no handshake.
module bit8_manipulator (
    input  logic [7:0] din,
    input  logic       dir_right,
    input  logic       rotate,
    output logic [7:0] dout,
    output logic       bit_out
);
    always_comb begin
        if (dir_right) begin
            dout    = {rotate & din[0], din[7:1]};
            bit_out = din[0];
        end else begin
            dout    = {din[6:0], rotate & din[7]};
            bit_out = din[7];
        end
    end
endmodule

// File: rtl/mux2to1.sv
// Two-input word mux; purely combinational, no handshake.
module mux2to1 #(
    parameter int W = 8
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences ALU commands over the shared adder/manipulator: 1 cycle for ADD/SUB/PASS,
// max(n,1) for shifts, 8 for MUL; holds the response until rsp_ready, one command at a time.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_cout,
    output logic        rsp_zero,
    output logic        busy
);
    state_t state, state_nxt;
    logic   load, step, finish, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid && cmd_ready) state_nxt = EXEC;
            EXEC:    if (last) state_nxt = DONE;
            DONE:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load   = (state == IDLE) && cmd_valid && cmd_ready;
        step   = (state == EXEC);
        finish = (state == EXEC) && last;
        busy   = (state != IDLE);
    end

    alu_seq_datapath u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .finish (finish),
        .in_op  (cmd_op),
        .in_a   (cmd_a),
        .in_b   (cmd_b),
        .last   (last),
        .result (rsp_result),
        .cout   (rsp_cout),
        .zero   (rsp_zero)
    );
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer against an arithmetic reference model.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'b000;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_cout;
    logic        rsp_zero;
    logic        busy;

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        zero;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic hold_off = 1'b0;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ai, bi, n, r, c, lat;
        ai = int'(a); bi = int'(b); n = int'(b[2:0]);
        c = 0; lat = 1;
        case (op)
            OP_ADD: begin r = ai + bi; c = r >> 8; r = r & 255; end
            OP_SUB: begin r = ai + (255 - bi) + 1; c = r >> 8; r = r & 255; end
            OP_SHL: begin r = (ai << n) & 255; c = (n > 0) ? ((ai >> (8 - n)) & 1) : 0; end
            OP_SHR: begin r = ai >> n; c = (n > 0) ? ((ai >> (n - 1)) & 1) : 0; end
            OP_ROL: begin r = ((ai << n) | (ai >> (8 - n))) & 255; c = (n > 0) ? (r & 1) : 0; end
            OP_ROR: begin r = ((ai >> n) | (ai << (8 - n))) & 255; c = (n > 0) ? ((r >> 7) & 1) : 0; end
            OP_MUL: begin r = ai * bi; lat = 8; end
            default: r = ai;
        endcase
        if (op >= OP_SHL && op <= OP_ROR && n > 0) lat = n;
        e.res = r[15:0]; e.cout = c[0]; e.zero = (r == 0); e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        bit   got = 1'b0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; break; end
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e = model(op, a, b);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) return;
        end
        check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            rsp_ready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard when a response appears, then checks it holds until taken.
    exp_t        cur;
    logic        pv = 1'b0, hs = 1'b0, hs_was;
    logic [15:0] h_res;
    logic        h_cout, h_zero;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0; hs = 1'b0;
        end else begin
            hs_was = hs;
            if (hs) begin
                check("ready_after_handshake", 32'(cmd_ready), 32'd1);
                check("valid_after_handshake", 32'(rsp_valid), 32'd0);
                hs = 1'b0;
            end
            if (pv && !rsp_valid && !hs_was) check("valid_dropped_early", 32'(rsp_valid), 32'd1);
            if (rsp_valid) begin
                check("ready_while_done", 32'(cmd_ready), 32'd0);
                check("busy_while_done", 32'(busy), 32'd1);
                if (!pv) begin
                    if (q.size() == 0) begin
                        check("unexpected_response", 32'(rsp_valid), 32'd0);
                    end else begin
                        cur = q.pop_front();
                        check("result", 32'(rsp_result), 32'(cur.res));
                        check("cout", 32'(rsp_cout), 32'(cur.cout));
                        check("zero", 32'(rsp_zero), 32'(cur.zero));
                        check("latency", cyc - cur.acc, cur.lat);
                    end
                    h_res = rsp_result; h_cout = rsp_cout; h_zero = rsp_zero;
                end else begin
                    check("result_stable", 32'({rsp_result, rsp_cout, rsp_zero}),
                          32'({h_res, h_cout, h_zero}));
                end
                if (rsp_ready) hs = 1'b1;
            end
            pv = rsp_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_outputs", 32'({rsp_result, rsp_cout, rsp_zero, busy}), 32'd0);
        rst_n = 1'b1;
        #1 check("ready_before_first_edge", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        issue(OP_ADD, 8'hFF, 8'h01);
        issue(OP_SUB, 8'h05, 8'h07);
        issue(OP_ROL, 8'h81, 8'h03);
        issue(OP_SHR, 8'h81, 8'h00);
        issue(OP_MUL, 8'hFF, 8'hFF);
        issue(OP_MUL, 8'h00, 8'h37);
        issue(OP_PASS, 8'h00, 8'h12);

        for (int i = 0; i < 80; i++) begin
            issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain();

        // Backpressure: consumer stalls 5 cycles while a second command is held on the port.
        @(posedge clk); #1;
        hold_off = 1'b1;
        fork
            begin
                issue(OP_ROR, 8'h35, 8'h02);
                issue(OP_SUB, 8'h40, 8'h40);
            end
            begin
                bit seen = 1'b0;
                for (int t = 0; t < 100; t++) begin
                    @(negedge clk);
                    if (rsp_valid) begin seen = 1'b1; break; end
                end
                if (!seen) check("bp_valid_timeout", 32'd0, 32'd1);
                repeat (5) @(posedge clk);
                #1 hold_off = 1'b0;
            end
        join
        drain();

        // Reset in MUL EXEC cycle 4 must abort without a response.
        @(posedge clk); #1;
        hold_off = 1'b0;
        issue(OP_MUL, 8'h5A, 8'hC3);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        if (q.size() > 0) q.delete(q.size() - 1);
        @(negedge clk);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_outputs", 32'({rsp_result, rsp_cout, rsp_zero, busy, cmd_ready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 32'(cmd_ready), 32'd1);
        check("valid_after_abort", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        issue(OP_ADD, 8'h10, 8'h22);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that accepts ALU commands over a valid/ready handshake and sequences one shared 8-bit ripple adder (bit8_full_adder) and one single-step shifter/rotator (bit8_manipulator) to execute them.
- Multi-bit shifts and rotates run as repeated single steps; 8x8 multiply runs as iterative shift-add.
- Sits between the instruction decode front end and the ALU datapath. It is the only block that drives the adder and manipulator control inputs.

Parameters:
- DATA_W, 8, operand width. Fixed to 8 to match the adder and manipulator; any other value is unsupported.
- CNT_W, 3, width of the shift-amount and iteration counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  3  opcode: 000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 MUL, 111 PASS.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B. For shift and rotate ops only B[2:0] is used, as the amount.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_result  output  16  result.
- rsp_cout  output  1  carry or shifted-out bit.
- rsp_zero  output  1  asserted when rsp_result == 0.
- busy  output  1  asserted in EXEC or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, cmd_ready=0, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_zero=0, busy=0.
- cmd_ready is registered. It rises on the first clk edge after rst_n deasserts and is 1 only in IDLE.
- FSM IDLE -> EXEC: on cmd_valid && cmd_ready.
  - Latch op, A, B.
  - Load the counter: shift ops load B[2:0]; MUL loads 7.
  - Clear the accumulator and carry.
  - cmd_ready drops on the same edge.
- ADD: one EXEC cycle. Adder computes A+B+0. Result = {8'h00, sum}; cout = carry out.
- SUB: one EXEC cycle. Adder computes A+~B+1. Result = {8'h00, sum}; cout=1 means no borrow.
- PASS: one EXEC cycle. Result = {8'h00, A}; cout=0.
- SHL/SHR/ROL/ROR with amount n:
  - max(n,1) EXEC cycles. Each cycle applies one manipulator step to the working register; the counter decrements.
  - n=0: one EXEC cycle with no step; result = A, cout=0.
  - SHL/SHR fill with zero. ROL/ROR wrap the end bit.
  - cout = the last bit shifted out (shifts) or the last bit wrapped (rotates).
  - Result is zero-extended to 16 bits.
- MUL: exactly 8 EXEC cycles, unsigned shift-add.
  - Working state: {C, P_hi[7:0], Q[7:0]}, with Q initialised to B.
  - Each cycle: if Q[0]=1, {C, P_hi} = P_hi + A, else P_hi is unchanged and C=0. Then {C, P_hi, Q} is shifted right by 1.
  - Result = {P_hi, Q}; cout=0.
- EXEC -> DONE: when the last iteration completes (counter==0 or single-cycle op).
  - rsp_result, rsp_cout and rsp_zero are registered on that edge.
  - rsp_valid=1 from the next cycle.
- Latency from the accept edge to rsp_valid high:
  - ADD/SUB/PASS: 1 cycle.
  - Shifts: max(n,1) cycles.
  - MUL: 8 cycles.
- DONE: rsp_valid held at 1. rsp_result, rsp_cout and rsp_zero stay stable until rsp_valid && rsp_ready.
- DONE -> IDLE: on that handshake. rsp_valid drops and cmd_ready rises on the same edge.
- No command overlap and no bypass: a new command is accepted at the earliest one cycle after the response handshake.
- cmd_valid in EXEC or DONE is ignored. The requester must hold the command until cmd_ready.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Reset mid-operation (any state): abort immediately, discard latched operands, no response is produced, return to IDLE with reset values.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams: OP_ADD … OP_PASS, 3 bits;
  - state enum: IDLE, EXEC, DONE;
  - MUL_ITER = 8.
- One sub-module, alu_seq_datapath. It instantiates bit8_full_adder and bit8_manipulator, plus the working register, accumulator and operand-select muxing (built from mux2to1). It takes control strobes from the FSM.

Test Plan:
- ADD A=0xFF, B=0x01 -> 1 cycle after accept: rsp_valid=1, rsp_result=0x0000, rsp_cout=1, rsp_zero=1.
- SUB A=0x05, B=0x07 -> rsp_result=0x00FE, rsp_cout=0, rsp_zero=0.
- ROL A=0x81, B=3 -> rsp_valid 3 cycles after accept, rsp_result=0x000C, rsp_cout=0. SHR A=0x81, B=0 -> 1 cycle after accept, rsp_result=0x0081, rsp_cout=0.
- MUL A=0xFF, B=0xFF -> rsp_valid 8 cycles after accept, rsp_result=0xFE01. MUL A=0x00, B=0x37 -> rsp_result=0x0000, rsp_zero=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid while driving cmd_valid=1. Required: result stable, cmd_ready=0, no second accept. After the handshake, cmd_ready=1 on the next cycle.
- Assert rst_n=0 in MUL EXEC cycle 4 -> rsp_valid never asserts for that command. After release, cmd_ready=1 one edge later, and ADD 0x10+0x22 returns 0x0032.
